cam_capture_wr: RTL and testbench
=================================

Name: cam_capture_wr

Overview:
- Write-side producer for the dual-port frame buffer.
- Samples the OV7670 parallel pixel bus (VSYNC/HREF/D[7:0]) in RGB565 mode and packs each 2-byte pixel into RGB332.
- Drives the buffer's write port: address, data and write strobe.
- Started and monitored by the LM32 through start/busy/done.

Parameters:
- AW, 15, buffer address width in bits.
- DW, 8, buffer data width in bits; fixed RGB332 packing requires 8.
- IMG_W, 160, pixels per line captured.
- IMG_H, 120, lines per frame captured.

Ports:
- clk  in  1  camera PCLK; the only clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to capture a frame.
- cont  in  1  1 = continuous capture after start; 0 = single frame.
- vsync  in  1  camera VSYNC; high = vertical blanking.
- href  in  1  camera HREF; high = valid bytes on px_data.
- px_data  in  8  camera data byte.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  buffer write data, RGB332.
- px_wr  out  1  buffer write strobe, one cycle per pixel.
- busy  out  1  high while armed or capturing.
- done  out  1  one-cycle pulse at end of a captured frame.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs and internal registers, and forces state IDLE.
- Camera inputs are registered once on entry. All camera timing below refers to the registered copies.
- FSM states: IDLE, WAIT_VS, BYTE1, BYTE2.
  - IDLE: busy=0. start=1 -> WAIT_VS.
  - WAIT_VS: busy=1. Wait for a vsync falling edge (1 then 0); on it, mem_px_addr<=0 and go to BYTE1. A capture never begins mid-frame.
  - BYTE1: if href=1, latch byte as hi and go to BYTE2.
  - BYTE2: if href=1, latch byte as lo, issue a write, go to BYTE1. If href=0 (odd byte count on a line), discard hi and go to BYTE1.
- Packing: mem_px_data = {hi[7:5], hi[2:0], lo[4:3]} (R3 G3 B2).
- Write latency:
  - px_wr=1 with mem_px_data valid on the cycle after the lo byte is sampled.
  - mem_px_addr holds the address being written while px_wr=1.
  - Address increments by 1 on the following cycle.
- Address limit:
  - Last legal address is IMG_W*IMG_H-1 (19199 at defaults).
  - Once that address has been written, further pixels in the frame are dropped: px_wr stays 0 and the address holds.
- Frame end: a vsync rising edge in BYTE1/BYTE2 produces done=1 for one cycle.
  - cont=0: go to IDLE, busy=0 on the same cycle as done.
  - cont=1: go to WAIT_VS.
  - done also fires on a short frame, with fewer than IMG_W*IMG_H pixels written.
- start while busy is ignored. cont is sampled every cycle; clearing it mid-frame ends capture at the current frame's end.
- Reset mid-frame aborts with no further px_wr. The next capture waits for a fresh vsync falling edge.
- Idle outputs: px_wr=0 whenever not in a write cycle. mem_px_data keeps its last value.

Optional Feature:
- Macro CAM_TEST_PATTERN_EN.
- Defined:
  - Extra input test_en (1 bit).
  - With test_en=1, packed pixel data is replaced by 8 vertical color bars: bar = column index * 8 / IMG_W.
  - Bar colors are FF, FC, 1F, 1C, E3, E0, 03, 00.
  - Timing, address and strobe are unchanged.
- Undefined: port absent, camera data always used.

Decomposition:
- Shared package / include holds:
  - FSM state encodings (2-bit).
  - Default IMG_W/IMG_H.
  - RGB332 bar-color constants.
- Optional sub-module rgb565_to_332: combinational hi/lo -> 8-bit pack, reused by the VGA test path.
- Column counter and FSM stay in cam_capture_wr.

Test Plan:
- Reset: rst_n=0 for 3 clks mid-stream -> px_wr=0, busy=0, done=0, mem_px_addr=0, state IDLE.
- Single pixel: start, vsync 1->0, href=1 with bytes F8,1F -> one px_wr at addr 0 with data E3. With bytes 07,E0 -> data 1C.
- Full frame: 120 lines x 320 bytes, then vsync rise -> exactly 19200 writes at addr 0..19199, one done pulse, busy=0 after.
- Overflow/odd: 121 lines, plus one line with 321 bytes -> no writes beyond 19199; the odd trailing byte produces no write.
- Start mid-frame: start while vsync=0 and href active -> no px_wr until the next vsync 1->0.
- Continuous: cont=1, three frames -> three done pulses, address restarts at 0 each frame, busy held 1. Clear cont in frame 3 -> IDLE after its done.

Source files
------------

// File: rtl/cam_capture_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module : cam_capture_wr_pkg
// Brief  : Shared FSM encoding, default image size and RGB332 bar colours.
// Rev    : 1.0
// ============================================================================
package cam_capture_wr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        BYTE1   = 2'd2,
        BYTE2   = 2'd3
    } state_e;

    localparam int C_IMG_W_DEF = 160;
    localparam int C_IMG_H_DEF = 120;

    localparam logic [7:0] C_BAR_WHITE   = 8'hFF;
    localparam logic [7:0] C_BAR_YELLOW  = 8'hFC;
    localparam logic [7:0] C_BAR_CYAN    = 8'h1F;
    localparam logic [7:0] C_BAR_GREEN   = 8'h1C;
    localparam logic [7:0] C_BAR_MAGENTA = 8'hE3;
    localparam logic [7:0] C_BAR_RED     = 8'hE0;
    localparam logic [7:0] C_BAR_BLUE    = 8'h03;
    localparam logic [7:0] C_BAR_BLACK   = 8'h00;

    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        logic [7:0] color;
        case (idx)
            3'd0:    color = C_BAR_WHITE;
            3'd1:    color = C_BAR_YELLOW;
            3'd2:    color = C_BAR_CYAN;
            3'd3:    color = C_BAR_GREEN;
            3'd4:    color = C_BAR_MAGENTA;
            3'd5:    color = C_BAR_RED;
            3'd6:    color = C_BAR_BLUE;
            default: color = C_BAR_BLACK;
        endcase
        return color;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_capture_wr_rgb565_to_332.sv
`default_nettype none
// ============================================================================
// Module : cam_capture_wr_rgb565_to_332
// Brief  : Combinational pack of an RGB565 hi/lo byte pair into RGB332.
// Rev    : 1.0
// ============================================================================
module cam_capture_wr_rgb565_to_332 (
    input  logic [7:0] hi_i,
    input  logic [7:0] lo_i,
    output logic [7:0] rgb332_o
);

    // Only R[4:2], the top of G and the top of B survive the pack.
    logic unused_bits;
    assign unused_bits = ^{hi_i[4:3], lo_i[7:5], lo_i[2:0]};

    assign rgb332_o = {hi_i[7:5], hi_i[2:0], lo_i[4:3]};

endmodule
`default_nettype wire

// File: rtl/cam_capture_wr.sv
`default_nettype none
// ============================================================================
// Module : cam_capture_wr
// Brief  : OV7670 RGB565 capture, packed to RGB332 into the frame buffer.
//          Define CAM_TEST_PATTERN_EN to add test_en (vertical colour bars).
// Rev    : 1.0
// ============================================================================
module cam_capture_wr
    import cam_capture_wr_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int IMG_W = C_IMG_W_DEF,
    parameter int IMG_H = C_IMG_H_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
`ifdef CAM_TEST_PATTERN_EN
    input  logic          test_en,
`endif
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    state_e        state_q, state_d;
    logic          vsync_q, vsync_prev_q, href_q;
    logic [7:0]    data_q;
    logic [7:0]    hi_q, hi_d;
    logic [AW-1:0] addr_q;
    logic          full_q;
    logic          px_wr_q, px_wr_d;
    logic          done_q, done_d;
    logic          addr_clr;
    logic [DW-1:0] pix_q;
    logic [7:0]    w_packed, w_pixel;
    logic          w_vs_fall, w_vs_rise;

    assign w_vs_fall = vsync_prev_q & ~vsync_q;
    assign w_vs_rise = ~vsync_prev_q & vsync_q;

    cam_capture_wr_rgb565_to_332 u_pack (
        .hi_i     (hi_q),
        .lo_i     (data_q),
        .rgb332_o (w_packed)
    );

`ifdef CAM_TEST_PATTERN_EN
    logic [15:0] col_q;
    logic [31:0] w_bar_raw;
    logic [2:0]  w_bar;

    // Lines longer than IMG_W stay on the last bar.
    assign w_bar_raw = ({16'd0, col_q} * 32'd8) / 32'(IMG_W);
    assign w_bar     = (w_bar_raw > 32'd7) ? 3'd7 : w_bar_raw[2:0];
    assign w_pixel   = test_en ? bar_color(w_bar) : w_packed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
        end else if (!href_q) begin
            col_q <= '0;
        end else if (state_q == BYTE2 && !w_vs_rise && col_q != 16'hFFFF) begin
            col_q <= col_q + 16'd1;
        end
    end
`else
    assign w_pixel = w_packed;
`endif

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        px_wr_d  = 1'b0;
        done_d   = 1'b0;
        addr_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (w_vs_fall) begin
                    addr_clr = 1'b1;
                    state_d  = BYTE1;
                end
            end
            BYTE1, BYTE2: begin
                if (w_vs_rise) begin
                    done_d  = 1'b1;
                    state_d = cont ? WAIT_VS : IDLE;
                end else if (state_q == BYTE1) begin
                    if (href_q) begin
                        hi_d    = data_q;
                        state_d = BYTE2;
                    end
                end else begin
                    // A lone hi byte at line end is simply dropped here.
                    px_wr_d = href_q & ~full_q;
                    state_d = BYTE1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            hi_q         <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            px_wr_q      <= 1'b0;
            done_q       <= 1'b0;
            pix_q        <= '0;
        end else begin
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
            href_q       <= href;
            data_q       <= px_data;
            state_q      <= state_d;
            hi_q         <= hi_d;
            px_wr_q      <= px_wr_d;
            done_q       <= done_d;
            if (px_wr_d) pix_q <= w_pixel;
            // Address advances the cycle after a write; the last slot latches full.
            if (addr_clr) begin
                addr_q <= '0;
                full_q <= 1'b0;
            end else if (px_wr_q) begin
                if (addr_q == C_LAST_ADDR) full_q <= 1'b1;
                else                       addr_q <= addr_q + AW'(1);
            end
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = pix_q;
    assign px_wr       = px_wr_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_wr.sv
`default_nettype none
// ============================================================================
// Module : tb_cam_capture_wr
// Brief  : Random camera frames checked against a byte-stream pixel model.
// Rev    : 1.0
// ============================================================================
module tb_cam_capture_wr;

    localparam int AW   = 15;
    localparam int DW   = 8;
    localparam int NPIX = 160 * 120;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          vsync = 1'b1;
    logic          href = 1'b0;
    logic [7:0]    px_data = 8'd0;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr, busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_busy_cnt = 0;
    int busy_drop_cnt = 0;
    logic expect_busy = 1'b0;

    logic [AW-1:0] got_addr[$];
    logic [7:0]    got_data[$];
    logic [7:0]    exp_data[$];
    int            line_len[$];
    logic [7:0]    fixed_bytes[$];

    always #5 clk = ~clk;

    cam_capture_wr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cont        (cont),
        .vsync       (vsync),
        .href        (href),
        .px_data     (px_data),
`ifdef CAM_TEST_PATTERN_EN
        .test_en     (1'b0),
`endif
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .busy        (busy),
        .done        (done)
    );

    always @(negedge clk) begin
        if (px_wr) begin
            got_addr.push_back(mem_px_addr);
            got_data.push_back(mem_px_data);
        end
        if (done) begin
            done_cnt++;
            if (busy) done_busy_cnt++;
        end
        if (expect_busy && !busy) busy_drop_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pack332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        vsync   = vs;
        href    = hr;
        px_data = d;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        @(posedge clk);
        got_addr.delete();
        got_data.delete();
        exp_data.delete();
        done_cnt      = 0;
        done_busy_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Blanking, then each line of line_len[] bytes, then the vsync rise.
    task automatic run_frame(input bit armed, input bit drop_cont);
        logic [7:0] line_bytes[$];
        logic [7:0] b;
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        repeat (3) drive(1'b0, 1'b0, 8'd0);
        foreach (line_len[i]) begin
            line_bytes.delete();
            for (int k = 0; k < line_len[i]; k++) begin
                if (fixed_bytes.size() > 0) b = fixed_bytes.pop_front();
                else                        b = 8'($urandom);
                line_bytes.push_back(b);
                drive(1'b0, 1'b1, b);
            end
            if (armed) begin
                for (int k = 0; k + 1 < line_bytes.size(); k += 2) begin
                    if (exp_data.size() < NPIX) exp_data.push_back(pack332(line_bytes[k], line_bytes[k+1]));
                end
            end
            if (drop_cont && i == 0) cont = 1'b0;
            repeat (2) drive(1'b0, 1'b0, 8'd0);
        end
        repeat (4) drive(1'b1, 1'b0, 8'd0);
    endtask

    task automatic compare_frame(input string tag);
        int e0;
        check_val({tag, "_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            e0 = errors;
            check_val({tag, "_addr"}, 32'(got_addr[i]), i);
            check_val({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
            if (errors != e0) break;
        end
    endtask

    task automatic random_lines(input int max_lines);
        int n;
        line_len.delete();
        n = $urandom_range(1, max_lines);
        for (int k = 0; k < n; k++) line_len.push_back($urandom_range(0, 21));
    endtask

    initial begin
        int sz0;

        // Reset while the camera is streaming.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vsync   = 1'b0;
            href    = k[0];
            px_data = 8'($urandom);
        end
        #1;
        check_val("rst_px_wr", px_wr, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_addr", mem_px_addr, 0);
        check_val("rst_data", mem_px_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        settle();
        check_val("idle_busy", busy, 0);

        // Single pixels with known colours.
        for (int t = 0; t < 2; t++) begin
            clear_obs();
            cont = 1'b0;
            pulse_start();
            line_len.delete();
            line_len.push_back(2);
            fixed_bytes.delete();
            if (t == 0) begin
                fixed_bytes.push_back(8'hF8);
                fixed_bytes.push_back(8'h1F);
            end else begin
                fixed_bytes.push_back(8'h07);
                fixed_bytes.push_back(8'hE0);
            end
            run_frame(1'b1, 1'b0);
            compare_frame("px1");
            if (got_data.size() > 0) check_val("px1_const", got_data[0], (t == 0) ? 8'hE3 : 8'h1C);
            check_val("px1_done", done_cnt, 1);
            check_val("px1_done_busy", done_busy_cnt, 0);
            settle();
            check_val("px1_busy_after", busy, 0);
        end

        // Random short frames, odd and empty lines included.
        for (int f = 0; f < 6; f++) begin
            clear_obs();
            pulse_start();
            random_lines(4);
            run_frame(1'b1, 1'b0);
            compare_frame("rnd");
            check_val("rnd_done", done_cnt, 1);
            check_val("rnd_done_busy", done_busy_cnt, 0);
            settle();
            check_val("rnd_busy_after", busy, 0);
        end

        // Start during an active line must wait for the next vsync fall.
        clear_obs();
        repeat (2) drive(1'b1, 1'b0, 8'd0);
        repeat (3) drive(1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vsync   = 1'b0;
            href    = 1'b1;
            px_data = 8'($urandom);
            start   = (k == 4);
        end
        @(negedge clk);
        href  = 1'b0;
        start = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 8'd0);
        check_val("mid_no_wr", got_data.size(), 0);
        settle();
        check_val("mid_busy", busy, 1);
        line_len.delete();
        line_len.push_back(6);
        line_len.push_back(5);
        run_frame(1'b1, 1'b0);
        compare_frame("mid");
        check_val("mid_done", done_cnt, 1);

        // Oversized frame: odd first line, then 120 full lines.
        clear_obs();
        pulse_start();
        line_len.delete();
        line_len.push_back(321);
        repeat (120) line_len.push_back(320);
        run_frame(1'b1, 1'b0);
        compare_frame("full");
        check_val("full_writes", got_data.size(), NPIX);
        if (got_addr.size() > 0) check_val("full_last_addr", got_addr[got_addr.size()-1], NPIX - 1);
        check_val("full_done", done_cnt, 1);
        settle();
        check_val("full_busy_after", busy, 0);
        check_val("full_addr_hold", mem_px_addr, NPIX - 1);

        // Continuous capture, cont dropped during the third frame.
        clear_obs();
        cont = 1'b1;
        pulse_start();
        settle();
        expect_busy   = 1'b1;
        busy_drop_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            random_lines(3);
            if (f == 2) expect_busy = 1'b0;
            run_frame(1'b1, f == 2);
            compare_frame("cont");
            check_val("cont_done", done_cnt, 1);
            settle();
            check_val("cont_busy", busy, (f < 2) ? 1 : 0);
        end
        check_val("cont_busy_held", busy_drop_cnt, 0);

        // Reset in the middle of a line aborts the capture.
        clear_obs();
        cont = 1'b0;
        pulse_start();
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        repeat (3) drive(1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 8'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) drive(1'b0, 1'b1, 8'($urandom));
        #1;
        check_val("rst2_px_wr", px_wr, 0);
        check_val("rst2_busy", busy, 0);
        check_val("rst2_done", done, 0);
        check_val("rst2_addr", mem_px_addr, 0);
        sz0 = got_data.size();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 8'($urandom));
        repeat (2) drive(1'b0, 1'b0, 8'd0);
        repeat (4) drive(1'b1, 1'b0, 8'd0);
        check_val("rst2_no_wr", got_data.size(), sz0);
        check_val("rst2_no_done", done_cnt, 0);
        settle();
        check_val("rst2_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
